// File: rtl/cal_uart_pkg.sv
// rtl/cal_uart_pkg.sv - shared types, op codes and ASCII constants for the calculator UART sequencer
package cal_uart_pkg;

   typedef enum logic [3:0] {
      WAIT_A,
      WAIT_OP,
      WAIT_B,
      WAIT_EQ,
      CALC,
      SEND_SIGN,
      SEND_MSB,
      SEND_LSB,
      SEND_ERR,
      SEND_EOL
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] code;
   } op_dec_t;

   localparam logic [3:0] OP_MUL = 4'd10;
   localparam logic [3:0] OP_ADD = 4'd11;
   localparam logic [3:0] OP_SUB = 4'd13;
   localparam logic [3:0] OP_DIV = 4'd15;

   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_NINE  = 8'h39;
   localparam logic [7:0] CH_EQ    = 8'h3D;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_QMARK = 8'h3F;
   localparam logic [7:0] CH_E     = 8'h45;

   function automatic op_dec_t char_to_op(input logic [7:0] ch);
      op_dec_t d;
      d = '{valid: 1'b1, code: 4'd0};
      case (ch)
         8'h2A:   d.code = OP_MUL;
         8'h2B:   d.code = OP_ADD;
         8'h2D:   d.code = OP_SUB;
         8'h2F:   d.code = OP_DIV;
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cal_uart_ctrl.sv
// rtl/cal_uart_ctrl.sv - parses "<digit><op><digit>=" from UART RX, drives the BCD calculator, streams the ASCII result to TX
module cal_uart_ctrl
   import cal_uart_pkg::*;
#(
   parameter logic [7:0] EOL_CHAR      = 8'h0D,
   parameter int          SUPPRESS_ZERO = 1,
   parameter int          TIMEOUT_CYC   = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [3:0] cal_a,
   output logic [3:0] cal_op,
   output logic [3:0] cal_b,
   input  logic       cal_sign,
   input  logic [3:0] cal_msb,
   input  logic [3:0] cal_lsb,
   output logic       busy,
   output logic [7:0] err_cnt
);

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

   state_t      state;
   logic [31:0] timer;
   logic        res_sign;
   logic [3:0]  res_msb;
   logic [3:0]  res_lsb;

   logic        is_digit;
   logic        is_space;
   op_dec_t     op_dec;
   logic        in_wait;
   logic        sending;
   logic        bad_class;
   logic        parse_err;
   logic        overrun;
   logic        timeout;
   logic [3:0]  msb_src;
   logic [3:0]  lsb_src;
   state_t      tail_state;
   logic [7:0]  tail_byte;

   assign is_digit = (rx_data >= CH_ZERO) && (rx_data <= CH_NINE);
   assign is_space = (rx_data == CH_SPACE);
   assign op_dec   = char_to_op(rx_data);
   assign in_wait  = (state == WAIT_OP) || (state == WAIT_B) || (state == WAIT_EQ);
   assign sending  = !in_wait && (state != WAIT_A);
   assign busy     = (state != WAIT_A);

   always_comb begin
      bad_class = 1'b0;
      case (state)
         WAIT_A:  bad_class = !is_digit;
         WAIT_OP: bad_class = !op_dec.valid;
         WAIT_B:  bad_class = !is_digit;
         WAIT_EQ: bad_class = (rx_data != CH_EQ);
         default: bad_class = 1'b0;
      endcase
   end

   assign parse_err = rx_valid && !is_space && bad_class;
   assign overrun   = rx_valid && sending;
   assign timeout   = (TIMEOUT_CYC != 0) && in_wait && !rx_valid && (timer == TMO_LAST);

   // In CALC the result registers are being loaded, so pick the byte after the sign straight from the datapath.
   always_comb begin
      msb_src = (state == CALC) ? cal_msb : res_msb;
      lsb_src = (state == CALC) ? cal_lsb : res_lsb;
      if ((msb_src != 4'd0) || (SUPPRESS_ZERO == 0)) begin
         tail_state = SEND_MSB;
         tail_byte  = CH_ZERO | {4'h0, msb_src};
      end else begin
         tail_state = SEND_LSB;
         tail_byte  = CH_ZERO | {4'h0, lsb_src};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_A;
         timer    <= 32'd0;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         cal_a    <= 4'd0;
         cal_op   <= 4'd0;
         cal_b    <= 4'd0;
         res_sign <= 1'b0;
         res_msb  <= 4'd0;
         res_lsb  <= 4'd0;
         err_cnt  <= 8'd0;
      end else begin
         if ((parse_err || overrun || timeout) && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;

         if (!in_wait || rx_valid)
            timer <= 32'd0;
         else
            timer <= timer + 32'd1;

         if (parse_err) begin
            state    <= SEND_ERR;
            tx_data  <= CH_QMARK;
            tx_valid <= 1'b1;
         end else if (timeout) begin
            state <= WAIT_A;
         end else begin
            case (state)
               WAIT_A: if (rx_valid && is_digit) begin
                  cal_a <= rx_data[3:0];
                  state <= WAIT_OP;
               end
               WAIT_OP: if (rx_valid && op_dec.valid) begin
                  cal_op <= op_dec.code;
                  state  <= WAIT_B;
               end
               WAIT_B: if (rx_valid && is_digit) begin
                  cal_b <= rx_data[3:0];
                  state <= WAIT_EQ;
               end
               WAIT_EQ: if (rx_valid && (rx_data == CH_EQ))
                  state <= CALC;
               CALC: begin
                  res_sign <= cal_sign;
                  res_msb  <= cal_msb;
                  res_lsb  <= cal_lsb;
                  tx_valid <= 1'b1;
                  if ((cal_op == OP_DIV) && (cal_b == 4'd0)) begin
                     state   <= SEND_ERR;
                     tx_data <= CH_E;
                  end else if (cal_sign) begin
                     state   <= SEND_SIGN;
                     tx_data <= CH_MINUS;
                  end else begin
                     state   <= tail_state;
                     tx_data <= tail_byte;
                  end
               end
               SEND_SIGN: if (tx_ready) begin
                  state   <= tail_state;
                  tx_data <= tail_byte;
               end
               SEND_MSB: if (tx_ready) begin
                  state   <= SEND_LSB;
                  tx_data <= CH_ZERO | {4'h0, res_lsb};
               end
               SEND_LSB, SEND_ERR: if (tx_ready) begin
                  state   <= SEND_EOL;
                  tx_data <= EOL_CHAR;
               end
               SEND_EOL: if (tx_ready) begin
                  state    <= WAIT_A;
                  tx_valid <= 1'b0;
               end
               default: state <= WAIT_A;
            endcase
         end
      end
   end

endmodule
